// File: rtl/ula_pkg.sv
// ula_pkg: shared opcode, flag-index and width definitions for the ULA
package ula_pkg;
  localparam int WIDTH_DEFAULT = 32;
  typedef enum logic [1:0] {OP_ADD = 2'b00, OP_SUB = 2'b01, OP_AND = 2'b10, OP_OR = 2'b11} ula_op_e;
  localparam int FLG_N = 3;
  localparam int FLG_Z = 2;
  localparam int FLG_C = 1;
  localparam int FLG_V = 0;
endpackage

// File: rtl/ula_addsub.sv
// ula_addsub: single shared adder; subtraction as a + ~b + 1
module ula_addsub #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  logic [WIDTH-1:0] bx;
  assign bx = sub ? ~b : b;
  assign {cout, sum} = {1'b0, a} + {1'b0, bx} + {{WIDTH{1'b0}}, sub};
  // comparing against the inverted operand covers both the ADD and SUB overflow rules
  assign ovf = (a[WIDTH-1] == bx[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
endmodule

// File: rtl/ula_core.sv
// ula_core: 32-bit ADD/SUB/AND/OR unit with combinational result and registered result/flags
module ula_core
  import ula_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_q,
  output logic [3:0]       flags_q
);
  ula_op_e          op_e;
  logic [WIDTH-1:0] sum;
  logic             cout, ovf, arith;
  logic [3:0]       flags;
  assign op_e  = ula_op_e'(op);
  assign arith = (op_e == OP_ADD) || (op_e == OP_SUB);
  ula_addsub #(.WIDTH(WIDTH)) u_addsub (
    .a(a), .b(b), .sub(op_e == OP_SUB), .sum(sum), .cout(cout), .ovf(ovf)
  );
  always_comb begin
    result = (op_e == OP_AND) ? (a & b) : (op_e == OP_OR) ? (a | b) : sum;
    flags = 4'b0000;
    flags[FLG_N] = result[WIDTH-1];
    flags[FLG_Z] = (result == '0);
    flags[FLG_C] = arith & cout;
    flags[FLG_V] = arith & ovf;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result_q <= '0;
      flags_q  <= 4'b0000;
    end else begin
      result_q <= result;
      flags_q  <= flags;
    end
  end
endmodule

// File: tb/tb_ula_core.sv
// tb_ula_core: directed vector table plus async-reset sequence for ula_core
module tb_ula_core;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  op = 2'b00;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic [31:0] result, result_q;
  logic [3:0]  flags_q;
  int n_cmp = 0;
  int n_bad = 0;

  ula_core dut (
    .clk(clk), .rst(rst), .op(op), .a(a), .b(b),
    .result(result), .result_q(result_q), .flags_q(flags_q)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic [3:0]  flg;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    // flags are {N,Z,C,V}
    vecs[0]  = '{2'b00, 32'd5,          32'd3,          32'd8,          4'b0000};
    vecs[1]  = '{2'b00, 32'hFFFFFFFF,   32'd1,          32'h0,          4'b0110};
    vecs[2]  = '{2'b00, 32'h7FFFFFFF,   32'd1,          32'h80000000,   4'b1001};
    vecs[3]  = '{2'b01, 32'd3,          32'd5,          32'hFFFFFFFE,   4'b1000};
    vecs[4]  = '{2'b01, 32'd7,          32'd7,          32'h0,          4'b0110};
    vecs[5]  = '{2'b10, 32'hF0F0F0F0,   32'h0FF00FF0,   32'h00F000F0,   4'b0000};
    vecs[6]  = '{2'b11, 32'hF0F0F0F0,   32'h0FF00FF0,   32'hFFF0FFF0,   4'b1000};
    vecs[7]  = '{2'b01, 32'h0,          32'd1,          32'hFFFFFFFF,   4'b1000};
    vecs[8]  = '{2'b01, 32'h80000000,   32'd1,          32'h7FFFFFFF,   4'b0011};
    vecs[9]  = '{2'b00, 32'h80000000,   32'h80000000,   32'h0,          4'b0111};
    vecs[10] = '{2'b10, 32'hFFFFFFFF,   32'h0,          32'h0,          4'b0100};
    vecs[11] = '{2'b01, 32'd5,          32'd3,          32'd2,          4'b0010};

    a = 32'd10; b = 32'd20; op = 2'b00;
    #2;
    chk("reset result_q", result_q, 32'h0);
    chk("reset flags_q", {28'h0, flags_q}, 32'h0);
    chk("result during reset", result, 32'd30);
    @(posedge clk); #1;
    chk("held reset result_q", result_q, 32'h0);
    rst = 1'b0;

    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      op = vecs[i].op; a = vecs[i].a; b = vecs[i].b;
      #1;
      chk($sformatf("vec%0d result", i), result, vecs[i].res);
      @(posedge clk); #1;
      chk($sformatf("vec%0d result_q", i), result_q, vecs[i].res);
      chk($sformatf("vec%0d flags_q", i), {28'h0, flags_q}, {28'h0, vecs[i].flg});
    end

    op = 2'b11; a = 32'hF0F0F0F0; b = 32'h0FF00FF0;
    @(posedge clk); #1;
    chk("pre-reset result_q", result_q, 32'hFFF0FFF0);
    chk("pre-reset flags_q", {28'h0, flags_q}, 32'h8);
    #2 rst = 1'b1;
    #1;
    chk("async rst result_q", result_q, 32'h0);
    chk("async rst flags_q", {28'h0, flags_q}, 32'h0);
    chk("async rst result live", result, 32'hFFF0FFF0);
    op = 2'b00; a = 32'd1; b = 32'd2;
    #1;
    chk("result tracks in reset", result, 32'd3);
    @(posedge clk); #1;
    chk("rst held across edge", result_q, 32'h0);
    #2 rst = 1'b0;
    #1;
    chk("no capture before edge", result_q, 32'h0);
    @(posedge clk); #1;
    chk("capture after release", result_q, 32'd3);
    chk("flags after release", {28'h0, flags_q}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
